// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM state type and baud divisor helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with enable/clear, tick on the last cycle of each bit
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Held at zero while disabled so every bit period starts from a clean count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !en || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input and registered tx line
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BW = $clog2(DATA_BITS);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
        end
    endgenerate

    state_t                 state, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [BW-1:0]          bit_cnt, bit_cnt_next;
    logic                   tx_next;
    logic                   done_next;
    logic                   accept;
    logic                   baud_tick;

    assign accept   = (state == IDLE) && tx_valid;
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != IDLE),
        .clr  (accept),
        .tick (baud_tick)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next   = tx_data;
                    bit_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (baud_tick) state_next = DATA;
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1)) state_next = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is registered from the next-state value so it changes on the same edge as the FSM.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            tx        <= tx_next;
            tx_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level behavioural model
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx #(
        .CLK_FREQ (400),
        .BAUD_RATE(100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: a frame accepted at edge N drives 10 bit slots of CPB cycles each,
    // then one idle cycle carrying tx_done; the next accept can come at edge N+41.
    int         e = 0;
    bit         m_active = 1'b0;
    int         m_n = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] acc_q[$];
    int         acc_e_q[$];
    int         done_q[$];
    logic [7:0] rx_q[$];

    function automatic logic frame_bit(input logic [7:0] b, input int d);
        int idx;
        idx = (d - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
        end else if (tx_valid && (!m_active || (e + 1 - m_n) >= FRAME + 1)) begin
            m_active <= 1'b1;
            m_n      <= e + 1;
            m_byte   <= tx_data;
            acc_q.push_back(tx_data);
            acc_e_q.push_back(e + 1);
        end
        e <= e + 1;
    end

    always @(negedge clk) begin : cmp
        int   j;
        logic etx, erdy, ebusy, edone;
        if (e > 0) begin
            j = e - m_n;
            if (m_active && j >= 0 && j < FRAME) begin
                etx = frame_bit(m_byte, j + 1);
                erdy = 1'b0; ebusy = 1'b1; edone = 1'b0;
            end else begin
                etx = 1'b1; erdy = 1'b1; ebusy = 1'b0;
                edone = m_active && (j == FRAME);
            end
            vectors++;
            if ({tx, tx_ready, tx_busy, tx_done} !== {etx, erdy, ebusy, edone}) begin
                miscompares++;
                $display("FAIL cycle %0d outputs tx/ready/busy/done got %b%b%b%b expected %b%b%b%b",
                         e, tx, tx_ready, tx_busy, tx_done, etx, erdy, ebusy, edone);
            end
            if (tx_done === 1'b1) done_q.push_back(e + 1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_accept_timeout", 0, 1);
    endtask

    // Serial monitor: finds the start edge, then samples each bit near its middle.
    task automatic rx_frame(output logic [9:0] s, output bit ok);
        ok = 1'b0;
        s  = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("rx_start_timeout", 0, 1);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        s[0] = tx;
        for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(negedge clk);
            s[k] = tx;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic [9:0] s1, s2;
        bit         ok1, ok2;
        int         gap;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset_tx", int'(tx), 1);
            check("reset_ready", int'(tx_ready), 1);
            check("reset_busy", int'(tx_busy), 0);
            check("reset_done", int'(tx_done), 0);
        end

        // Single byte 0xA5: mid-bit samples 0,1,0,1,0,0,1,0,1,1 (start first).
        acc_e_q.delete(); done_q.delete();
        fork
            begin send(8'hA5); @(negedge clk); tx_valid = 1'b0; end
            rx_frame(s1, ok1);
        join
        repeat (4) @(negedge clk);
        check("a5_rx_ok", int'(ok1), 1);
        check("a5_samples", int'(s1), 10'h34A);
        check("a5_done_count", done_q.size(), 1);
        if (done_q.size() == 1 && acc_e_q.size() == 1)
            check("a5_done_edge", done_q[0] - acc_e_q[0], 41);

        // Back-to-back 0x00 then 0xFF with tx_valid held.
        acc_e_q.delete(); done_q.delete();
        fork
            begin send(8'h00); send(8'hFF); @(negedge clk); tx_valid = 1'b0; end
            begin rx_frame(s1, ok1); rx_frame(s2, ok2); end
        join
        repeat (4) @(negedge clk);
        check("b2b_rx_ok", int'(ok1 & ok2), 1);
        check("b2b_byte0", int'(s1[8:1]), 8'h00);
        check("b2b_byte1", int'(s2[8:1]), 8'hFF);
        check("b2b_accepts", acc_e_q.size(), 2);
        if (acc_e_q.size() == 2) check("b2b_accept_gap", acc_e_q[1] - acc_e_q[0], 41);
        check("b2b_dones", done_q.size(), 2);
        if (done_q.size() == 2) check("b2b_done_gap", done_q[1] - done_q[0], 41);

        // Input changes after accept must not touch the frame in flight.
        acc_q.delete();
        fork
            begin
                send(8'h3C);
                @(negedge clk);
                tx_data = 8'hFF;
                repeat (20) begin @(negedge clk); tx_valid = ~tx_valid; end
                tx_valid = 1'b0;
            end
            rx_frame(s1, ok1);
        join
        repeat (4) @(negedge clk);
        check("stable_byte", int'(s1[8:1]), 8'h3C);
        check("stable_accepts", acc_q.size(), 1);

        // Reset during data bit 3 of 0x81, then a fresh 0x81.
        done_q.delete();
        send(8'h81);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", int'(tx), 1);
        check("midrst_ready", int'(tx_ready), 1);
        check("midrst_busy", int'(tx_busy), 0);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("midrst_no_done", done_q.size(), 0);
        fork
            begin send(8'h81); @(negedge clk); tx_valid = 1'b0; end
            rx_frame(s1, ok1);
        join
        repeat (4) @(negedge clk);
        check("midrst_fresh", int'(s1[8:1]), 8'h81);
        check("midrst_stop", int'(s1[9]), 1);

        // Scoreboard: random bytes with random valid gaps.
        acc_q.delete(); rx_q.delete();
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    gap = $urandom_range(0, 3);
                    send(8'($urandom));
                    if (gap != 0) begin
                        @(negedge clk);
                        tx_valid = 1'b0;
                        repeat (gap - 1) @(negedge clk);
                    end
                end
                @(negedge clk);
                tx_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 200; n++) begin
                    rx_frame(s1, ok1);
                    if (!ok1) break;
                    rx_q.push_back(s1[8:1]);
                    if (s1[9] !== 1'b1) check("sb_stop_bit", int'(s1[9]), 1);
                end
            end
        join
        repeat (4) @(negedge clk);
        check("sb_rx_count", rx_q.size(), 200);
        check("sb_acc_count", acc_q.size(), 200);
        for (int n = 0; n < 200 && n < rx_q.size() && n < acc_q.size(); n++)
            check($sformatf("sb_byte_%0d", n), int'(rx_q[n]), int'(acc_q[n]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
